// File: rtl/microcode_sequencer_pkg.sv
// Shared microcode definitions for the sequencer, microcode_rom and the
// microcode source: next-address opcodes, branch conditions, mc_word field
// positions and sequencer state encodings.
package microcode_sequencer_pkg;

    // Next-address opcode carried in mc_word.
    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'b000,
        SEQ_JUMP     = 3'b001,
        SEQ_BRCOND   = 3'b010,
        SEQ_DISPATCH = 3'b011,
        SEQ_FETCH    = 3'b100,
        SEQ_HALT     = 3'b101,
        SEQ_CALL     = 3'b110,
        SEQ_RET      = 3'b111
    } seq_op_e;

    // Branch condition select carried in mc_word.
    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_N      = 2'b10,
        COND_C      = 2'b11
    } cond_sel_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_IR = 2'd1,
        ST_HALTED  = 2'd2
    } seq_state_e;

    // Sequencing field positions inside mc_word (microcode_rom layout).
    localparam int MC_SEQ_OP_LSB    = 0;
    localparam int MC_SEQ_OP_MSB    = 2;
    localparam int MC_COND_SEL_LSB  = 3;
    localparam int MC_COND_SEL_MSB  = 4;
    localparam int MC_BR_TARGET_LSB = 5;
    localparam int MC_BR_TARGET_MSB = 10;

endpackage

// File: rtl/microcode_sequencer_dispatch_rom.sv
// Opcode -> micro-address dispatch table. Kept on its own so the opcode map
// can be edited without touching the sequencer. Unmapped opcodes land on the
// fetch routine, which makes an illegal instruction a NOP.
module mcseq_dispatch_rom #(
    parameter int                   UPC_WIDTH    = 6,
    parameter int                   OPCODE_WIDTH = 4,
    parameter logic [UPC_WIDTH-1:0] FETCH_ADDR   = '0
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [UPC_WIDTH-1:0]    target
);

    // Combinational opcode map; each routine starts on an 8-word boundary.
    always_comb begin
        // NOTE: default first so every path assigns target and no latch is inferred.
        target = FETCH_ADDR;
        case (opcode)
            OPCODE_WIDTH'(1): target = UPC_WIDTH'(8);   // LDA
            OPCODE_WIDTH'(2): target = UPC_WIDTH'(16);  // STA
            OPCODE_WIDTH'(3): target = UPC_WIDTH'(24);  // ADD
            OPCODE_WIDTH'(4): target = UPC_WIDTH'(32);  // SUB
            OPCODE_WIDTH'(5): target = UPC_WIDTH'(40);  // JMP
            OPCODE_WIDTH'(6): target = UPC_WIDTH'(48);  // JZ
            default:          target = FETCH_ADDR;
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Micro-program counter and next-address logic feeding microcode_rom.
// Optional micro-return stack (SEQ_CALL / SEQ_RET) is built only when
// MCSEQ_USTACK_EN is defined; otherwise CALL/RET act as SEQ_NEXT and
// ustack_err is tied low.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int                   UPC_WIDTH    = 6,
    parameter int                   OPCODE_WIDTH = 4,
    parameter logic [UPC_WIDTH-1:0] FETCH_ADDR   = '0,
    parameter int                   USTACK_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              seq_op,
    input  logic [UPC_WIDTH-1:0]    br_target,
    input  logic [1:0]              cond_sel,
    input  logic                    flag_z,
    input  logic                    flag_n,
    input  logic                    flag_c,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    ir_valid,
    input  logic                    stall,
    input  logic                    resume,
    output logic [UPC_WIDTH-1:0]    offset,
    output logic                    halted,
    output logic                    ustack_err
);

    seq_state_e           state, state_next;
    logic [UPC_WIDTH-1:0] offset_next;
    logic [UPC_WIDTH-1:0] offset_inc;
    logic [UPC_WIDTH-1:0] dispatch_addr;
    logic                 cond_true;
    seq_op_e              op;

    assign op         = seq_op_e'(seq_op);
    assign offset_inc = offset + UPC_WIDTH'(1);   // wraps modulo 2^UPC_WIDTH
    assign halted     = (state == ST_HALTED);

    mcseq_dispatch_rom #(
        .UPC_WIDTH   (UPC_WIDTH),
        .OPCODE_WIDTH(OPCODE_WIDTH),
        .FETCH_ADDR  (FETCH_ADDR)
    ) u_dispatch (
        .opcode(opcode),
        .target(dispatch_addr)
    );

`ifdef MCSEQ_USTACK_EN
    localparam int SP_W  = $clog2(USTACK_DEPTH + 1);
    localparam int IDX_W = (USTACK_DEPTH > 1) ? $clog2(USTACK_DEPTH) : 1;

    logic [UPC_WIDTH-1:0] ustack [USTACK_DEPTH];
    logic [SP_W-1:0]      sp;
    logic                 push, pop, err_set;
    logic [IDX_W-1:0]     push_idx, top_idx;

    assign push_idx = IDX_W'(sp);
    assign top_idx  = IDX_W'(sp - SP_W'(1));
`else
    assign ustack_err = 1'b0;
`endif

    // Select the branch condition named by cond_sel.
    always_comb begin
        cond_true = 1'b1;
        case (cond_sel_e'(cond_sel))
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = flag_z;
            COND_N:      cond_true = flag_n;
            COND_C:      cond_true = flag_c;
            default:     cond_true = 1'b1;
        endcase
    end

    // Next-state / next-address decision; stall freezes everything.
    always_comb begin
        state_next  = state;
        offset_next = offset;
`ifdef MCSEQ_USTACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
`endif
        if (!stall) begin
            case (state)
                ST_RUN: begin
                    case (op)
                        SEQ_NEXT:   offset_next = offset_inc;
                        SEQ_JUMP:   offset_next = br_target;
                        SEQ_BRCOND: offset_next = cond_true ? br_target : offset_inc;
                        SEQ_DISPATCH: begin
                            if (ir_valid) offset_next = dispatch_addr;
                            else          state_next  = ST_WAIT_IR;
                        end
                        SEQ_FETCH:  offset_next = FETCH_ADDR;
                        SEQ_HALT:   state_next  = ST_HALTED;
`ifdef MCSEQ_USTACK_EN
                        SEQ_CALL: begin
                            offset_next = br_target;
                            if (sp == SP_W'(USTACK_DEPTH)) err_set = 1'b1;
                            else                           push    = 1'b1;
                        end
                        SEQ_RET: begin
                            if (sp == '0) begin
                                offset_next = FETCH_ADDR;
                                err_set     = 1'b1;
                            end else begin
                                offset_next = ustack[top_idx];
                                pop         = 1'b1;
                            end
                        end
`else
                        SEQ_CALL, SEQ_RET: offset_next = offset_inc;
`endif
                        default:    offset_next = offset_inc;
                    endcase
                end
                ST_WAIT_IR: begin
                    if (ir_valid) begin
                        offset_next = dispatch_addr;
                        state_next  = ST_RUN;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        offset_next = FETCH_ADDR;
                        state_next  = ST_RUN;
                    end
                end
                default: begin
                    offset_next = FETCH_ADDR;
                    state_next  = ST_RUN;
                end
            endcase
        end
    end

    // State and micro-PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            offset <= FETCH_ADDR;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state  <= state_next;
            offset <= offset_next;
        end
    end

`ifdef MCSEQ_USTACK_EN
    // Stack pointer and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp         <= '0;
            ustack_err <= 1'b0;
        end else begin
            if (push)    sp <= sp + SP_W'(1);
            else if (pop) sp <= sp - SP_W'(1);
            if (err_set) ustack_err <= 1'b1;
        end
    end

    // Return-address storage.
    // NOTE: storage is not reset; sp==0 after reset marks every entry invalid.
    always_ff @(posedge clk) begin
        if (push) ustack[push_idx] <= offset_inc;
    end
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer. A behavioural model tracks the
// expected micro-address, halt state and stack error; a negedge process
// compares it with the DUT every cycle, and directed steps pin literal values.
// Stack tests are compiled when MCSEQ_USTACK_EN is defined.
module tb_microcode_sequencer;
    import microcode_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] seq_op = SEQ_FETCH;
    logic [5:0] br_target = '0;
    logic [1:0] cond_sel = '0;
    logic       flag_z = 1'b0, flag_n = 1'b0, flag_c = 1'b0;
    logic [3:0] opcode = '0;
    logic       ir_valid = 1'b0, stall = 1'b0, resume = 1'b0;
    logic [5:0] offset;
    logic       halted, ustack_err;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    microcode_sequencer dut (
        .clk(clk), .rst_n(rst_n), .seq_op(seq_op), .br_target(br_target),
        .cond_sel(cond_sel), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .opcode(opcode), .ir_valid(ir_valid), .stall(stall), .resume(resume),
        .offset(offset), .halted(halted), .ustack_err(ustack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int tbl[16];
    int m_off   = 0;
    bit m_halt  = 0;
    bit m_wait  = 0;
    bit m_err   = 0;
    int m_stack[$];

    initial begin
        foreach (tbl[i]) tbl[i] = 0;
        tbl[1] = 8; tbl[2] = 16; tbl[3] = 24; tbl[4] = 32; tbl[5] = 40; tbl[6] = 48;
    end

    function automatic bit cond_val(input logic [1:0] cs);
        if (cs == 2'd1) return flag_z;
        if (cs == 2'd2) return flag_n;
        if (cs == 2'd3) return flag_c;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_off = 0; m_halt = 0; m_wait = 0; m_err = 0;
            m_stack.delete();
        end else if (!stall) begin
            if (m_halt) begin
                if (resume) begin m_off = 0; m_halt = 0; end
            end else if (m_wait) begin
                if (ir_valid) begin m_off = tbl[opcode]; m_wait = 0; end
            end else begin
                case (seq_op)
                    3'd1: m_off = br_target;
                    3'd2: m_off = cond_val(cond_sel) ? int'(br_target) : (m_off + 1) % 64;
                    3'd3: if (ir_valid) m_off = tbl[opcode]; else m_wait = 1;
                    3'd4: m_off = 0;
                    3'd5: m_halt = 1;
`ifdef MCSEQ_USTACK_EN
                    3'd6: begin
                        if (m_stack.size() == 4) m_err = 1;
                        else m_stack.push_back((m_off + 1) % 64);
                        m_off = br_target;
                    end
                    3'd7: begin
                        if (m_stack.size() == 0) begin m_off = 0; m_err = 1; end
                        else m_off = m_stack.pop_back();
                    end
`endif
                    default: m_off = (m_off + 1) % 64;
                endcase
            end
        end
    end

    // Compare process: DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_offset", 32'(offset), 32'(m_off));
            check("model_halted", 32'(halted), 32'(m_halt));
            check("model_ustack_err", 32'(ustack_err), 32'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [2:0] op, input logic [5:0] tgt = 6'd0,
                        input logic [1:0] cs = 2'd0, input logic irv = 1'b0,
                        input logic [3:0] opc = 4'd0, input logic st = 1'b0,
                        input logic rs = 1'b0);
        @(negedge clk);
        seq_op = op; br_target = tgt; cond_sel = cs; ir_valid = irv;
        opcode = opc; stall = st; resume = rs;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check it acts without a clock, then release.
    task automatic async_reset(input string name);
        #2;
        seq_op = SEQ_FETCH; stall = 1'b0; resume = 1'b0;
        rst_n = 1'b0;
        #1;
        check({name, "_offset"}, 32'(offset), 32'd0);
        check({name, "_halted"}, 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_offset", 32'(offset), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_ustack_err", 32'(ustack_err), 32'd0);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // model pins
        check("table_op4", 32'(tbl[4]), 32'd32);
        check("table_op15", 32'(tbl[15]), 32'd0);

        // sequential stepping after reset
        step(SEQ_NEXT); check("next_1", 32'(offset), 32'd1);
        step(SEQ_NEXT); check("next_2", 32'(offset), 32'd2);
        step(SEQ_NEXT); check("next_3", 32'(offset), 32'd3);
        step(SEQ_NEXT); check("next_4", 32'(offset), 32'd4);
        async_reset("midrun_reset");

        // wrap and jump
        step(SEQ_JUMP, 6'd63); check("jump_63", 32'(offset), 32'd63);
        step(SEQ_NEXT);        check("wrap_0", 32'(offset), 32'd0);
        step(SEQ_JUMP, 6'd40); check("jump_40", 32'(offset), 32'd40);

        // conditional branches
        step(SEQ_JUMP, 6'd5); flag_z = 1'b1;
        step(SEQ_BRCOND, 6'd20, 2'd1); check("brz_taken", 32'(offset), 32'd20);
        step(SEQ_JUMP, 6'd5); flag_z = 1'b0;
        step(SEQ_BRCOND, 6'd20, 2'd1); check("brz_not", 32'(offset), 32'd6);
        step(SEQ_JUMP, 6'd5); flag_n = 1'b1;
        step(SEQ_BRCOND, 6'd20, 2'd2); check("brn_taken", 32'(offset), 32'd20);
        step(SEQ_JUMP, 6'd5); flag_c = 1'b0;
        step(SEQ_BRCOND, 6'd20, 2'd3); check("brc_not", 32'(offset), 32'd6);
        step(SEQ_JUMP, 6'd5); flag_c = 1'b1;
        step(SEQ_BRCOND, 6'd20, 2'd3); check("brc_taken", 32'(offset), 32'd20);
        step(SEQ_BRCOND, 6'd9, 2'd0);  check("br_always", 32'(offset), 32'd9);

        // dispatch with IR wait
        step(SEQ_JUMP, 6'd3);
        step(SEQ_DISPATCH, 6'd0, 2'd0, 1'b0, 4'd4); check("disp_wait1", 32'(offset), 32'd3);
        step(SEQ_DISPATCH, 6'd0, 2'd0, 1'b0, 4'd4); check("disp_wait2", 32'(offset), 32'd3);
        step(SEQ_DISPATCH, 6'd0, 2'd0, 1'b1, 4'd4); check("disp_op4", 32'(offset), 32'd32);
        step(SEQ_DISPATCH, 6'd0, 2'd0, 1'b1, 4'd1); check("disp_op1", 32'(offset), 32'd8);
        step(SEQ_DISPATCH, 6'd0, 2'd0, 1'b1, 4'd15); check("disp_illegal", 32'(offset), 32'd0);
        step(SEQ_JUMP, 6'd7);
        step(SEQ_FETCH); check("fetch", 32'(offset), 32'd0);

        // stall
        step(SEQ_JUMP, 6'd10);
        step(SEQ_NEXT); check("pre_stall", 32'(offset), 32'd11);
        for (int i = 0; i < 3; i++) begin
            step(SEQ_NEXT, 6'd0, 2'd0, 1'b0, 4'd0, 1'b1);
            check("stall_hold", 32'(offset), 32'd11);
        end
        step(SEQ_NEXT); check("post_stall", 32'(offset), 32'd12);

        // halt / resume
        step(SEQ_JUMP, 6'd50);
        step(SEQ_HALT); check("halt_offset", 32'(offset), 32'd50);
        check("halt_flag", 32'(halted), 32'd1);
        step(SEQ_NEXT); check("halt_ignores_op", 32'(offset), 32'd50);
        step(SEQ_NEXT, 6'd0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("resume_stalled_off", 32'(offset), 32'd50);
        check("resume_stalled_halt", 32'(halted), 32'd1);
        step(SEQ_NEXT, 6'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("resume_offset", 32'(offset), 32'd0);
        check("resume_halted", 32'(halted), 32'd0);
        step(SEQ_JUMP, 6'd50);
        step(SEQ_HALT);
        async_reset("halt_reset");

`ifdef MCSEQ_USTACK_EN
        // micro-return stack
        step(SEQ_JUMP, 6'd10);
        step(SEQ_CALL, 6'd30); check("call_30", 32'(offset), 32'd30);
        step(SEQ_RET);         check("ret_11", 32'(offset), 32'd11);
        for (int i = 0; i < 4; i++) step(SEQ_CALL, 6'd30);
        check("call4_no_err", 32'(ustack_err), 32'd0);
        step(SEQ_CALL, 6'd30);
        check("call5_offset", 32'(offset), 32'd30);
        check("call5_err", 32'(ustack_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(SEQ_RET); check("ret_31", 32'(offset), 32'd31);
        end
        step(SEQ_RET); check("ret_12", 32'(offset), 32'd12);
        step(SEQ_RET); check("ret_empty", 32'(offset), 32'd0);
        check("err_sticky", 32'(ustack_err), 32'd1);
`else
        // without the stack CALL/RET step like SEQ_NEXT
        step(SEQ_JUMP, 6'd10);
        step(SEQ_CALL, 6'd30); check("call_as_next", 32'(offset), 32'd11);
        step(SEQ_RET);         check("ret_as_next", 32'(offset), 32'd12);
        check("no_stack_err", 32'(ustack_err), 32'd0);
`endif

        step(SEQ_NEXT);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
